// File: rtl/dq_history.sv
// Purpose : ADPCM predictor DQ history. Converts each accepted DQ to FLOATA DQn
//           form and streams the six (DQ, DQn) tap pairs to the XOR/UPB path,
//           then shifts the history by one sample.
// Latency : out_valid rises 1 cycle after the dq handshake. A sample takes at
//           least 8 cycles: 1 accept, 6 beats and 1 shift.
// Backpr. : dq_ready is low outside IDLE. While out_valid=1 and out_ready=0 the
//           beat (dq_out, dqn_out, tap, last) holds stable.
//
// Ports   : clk / reset (async, active-high); scan_* / test_mode are DFT
//           placeholders, and scan_out* are tied low. dq_in/dq_valid/dq_ready
//           form the sample input. dq_out/dqn_out/tap/last/out_valid/out_ready
//           form the tap stream.
// Option  : define DQ_HISTORY_HOMING_EN to add the 'homing' input. Homing in IDLE
//           reloads the history with RESET_DQN and takes priority over dq_valid.
module dq_history #(
    parameter int          NTAPS     = 6,
    parameter logic [10:0] RESET_DQN = 11'h020
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scan_in0,
    input  logic        scan_in1,
    input  logic        scan_in2,
    input  logic        scan_in3,
    input  logic        scan_in4,
    input  logic        scan_enable,
    input  logic        test_mode,
    output logic        scan_out0,
    output logic        scan_out1,
    output logic        scan_out2,
    output logic        scan_out3,
    output logic        scan_out4,
    input  logic [15:0] dq_in,
    input  logic        dq_valid,
    output logic        dq_ready,
    output logic [15:0] dq_out,
    output logic [10:0] dqn_out,
    output logic [2:0]  tap,
    output logic        out_valid,
    input  logic        out_ready,
`ifdef DQ_HISTORY_HOMING_EN
    input  logic        homing,
`endif
    output logic        last
);

    typedef enum logic [1:0] {IDLE, EMIT, SHIFT} state_t;

    localparam logic [2:0] LAST_TAP = 3'(NTAPS);

    state_t      r_state, w_state_nxt;
    logic [15:0] r_dq_out;
    logic [10:0] r_dq0;
    logic [2:0]  r_tap;
    logic [10:0] r_hist [1:NTAPS];

    logic        w_homing;
    logic        w_accept;
    logic [3:0]  w_exp;
    logic [20:0] w_mant_full;
    logic [5:0]  w_mant;
    logic [10:0] w_dq0;
    logic [10:0] w_dqn;
    logic        w_unused_scan;

    // Scan chains are stitched during scan insertion. The RTL only provides the ports.
    assign scan_out0     = 1'b0;
    assign scan_out1     = 1'b0;
    assign scan_out2     = 1'b0;
    assign scan_out3     = 1'b0;
    assign scan_out4     = 1'b0;
    assign w_unused_scan = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                             scan_enable, test_mode};

`ifdef DQ_HISTORY_HOMING_EN
    assign w_homing = homing;
`else
    assign w_homing = 1'b0;
`endif

    // FLOATA conversion. The exponent is 1 plus the MSB index of the magnitude.
    // The mantissa is the six bits just below and including the leading one.
    always_comb begin
        w_exp = 4'd0;
        for (int i = 0; i < 15; i++) begin
            if (dq_in[i]) w_exp = 4'(i + 1);
        end
    end

    assign w_mant_full = {dq_in[14:0], 6'b0} >> w_exp;
    assign w_mant      = (dq_in[14:0] == 15'd0) ? 6'h20 : w_mant_full[5:0];
    assign w_dq0       = {dq_in[15], w_exp, w_mant};

    // Tap mux. tap k selects history entry k, which is DQ0 from k samples ago.
    always_comb begin
        w_dqn = RESET_DQN;
        for (int i = 1; i <= NTAPS; i++) begin
            if (r_tap == 3'(i)) w_dqn = r_hist[i];
        end
    end

    assign w_accept = (r_state == IDLE) && !w_homing && dq_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        dq_ready    = 1'b0;
        out_valid   = 1'b0;
        last        = 1'b0;
        case (r_state)
            IDLE: begin
                dq_ready = !w_homing;
                if (w_accept) w_state_nxt = EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                last      = (r_tap == LAST_TAP);
                if (out_ready && r_tap == LAST_TAP) w_state_nxt = SHIFT;
            end
            SHIFT:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dq_out <= 16'd0;
            r_dq0    <= RESET_DQN;
            r_tap    <= 3'd1;
            for (int i = 1; i <= NTAPS; i++) r_hist[i] <= RESET_DQN;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_homing) begin
                        for (int i = 1; i <= NTAPS; i++) r_hist[i] <= RESET_DQN;
                    end else if (dq_valid) begin
                        r_dq_out <= dq_in;
                        r_dq0    <= w_dq0;
                        r_tap    <= 3'd1;
                    end
                end
                EMIT: begin
                    if (out_ready && r_tap != LAST_TAP) r_tap <= r_tap + 3'd1;
                end
                SHIFT: begin
                    // Taps were all emitted from the old history. The new sample is now inserted.
                    for (int i = NTAPS; i >= 2; i--) r_hist[i] <= r_hist[i-1];
                    r_hist[1] <= r_dq0;
                    r_tap     <= 3'd1;
                end
                default: r_tap <= 3'd1;
            endcase
        end
    end

    assign dq_out  = r_dq_out;
    assign dqn_out = w_dqn;
    assign tap     = r_tap;

endmodule

// File: doc/dq_history.md
Name: dq_history

Overview:
- Producer side of the XOR sign-correlation interface in the ADPCM adaptive predictor.
- Accepts one quantized difference DQ per sample and converts it to the 11-bit floating-point DQn format (G.726 FLOATA).
- Keeps the six-deep history DQ1..DQ6 and streams the six (DQ, DQn) tap pairs serially to the XOR/UPB path over a valid/ready handshake.
- Shifts the history once per sample, after all six taps have been delivered.

Parameters:
- NTAPS, 6, history depth; fixed at 6 for G.726, other values unsupported.
- RESET_DQN, 11'h020, history value loaded on reset (sign 0, exp 0, mant 32).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- scan_in0..scan_in4  input  1 each  scan chain inputs
- scan_enable  input  1  scan shift enable
- test_mode  input  1  DFT test mode
- scan_out0..scan_out4  output  1 each  scan chain outputs
- dq_in  input  16  current DQ, sign-magnitude: bit15 sign, [14:0] magnitude
- dq_valid  input  1  dq_in valid
- dq_ready  output  1  block can accept dq_in
- dq_out  output  16  registered current DQ, held for all six taps
- dqn_out  output  11  history entry DQn for the current tap
- tap  output  3  tap index, 1..6
- out_valid  output  1  dq_out/dqn_out/tap valid
- out_ready  input  1  consumer accepts the beat
- last  output  1  high with tap==6

Behaviour:
- Scan ports are functionally unused. Chains are stitched by scan insertion; RTL ties scan_outN to 0.
- Reset (async, active-high):
  - state=IDLE, dq_ready=1, out_valid=0, last=0, tap=1, dq_out=0, dqn_out=RESET_DQN.
  - All six history entries = RESET_DQN.
- FLOATA, computed combinationally on the captured DQ:
  - MAG=DQ[14:0].
  - EXP = 0 if MAG==0, else 1+index of MAG's MSB (range 0..15).
  - MANT = 6'h20 if MAG==0, else (MAG<<6)>>EXP, truncated to 6 bits.
  - DQ0 = {DQ[15], EXP[3:0], MANT[5:0]}.
- States:
  - IDLE: dq_ready=1. On dq_valid, capture dq_in into dq_out and DQ0 into a staging register; go to EMIT with tap=1.
  - EMIT: out_valid=1, dqn_out=history[tap]. On out_valid&out_ready with tap<6, increment tap. On out_valid&out_ready with tap==6, go to SHIFT.
  - SHIFT (one cycle, out_valid=0): history[6..2] <= history[5..1], history[1] <= staged DQ0. Then tap=1, go to IDLE.
- Emitted taps use the pre-update history: tap k of sample n is DQ0 of sample n-k.
- Latency:
  - dq handshake at cycle t puts out_valid high at t+1.
  - Minimum of 8 cycles per sample (1 accept + 6 beats + 1 shift).
  - dq_ready returns high at t+8 with zero backpressure.
- Backpressure: while out_valid=1 and out_ready=0, dq_out, dqn_out, tap and last hold stable. No tap is skipped or repeated.
- dq_in changes while dq_ready=0 are ignored.
- Reset mid-operation: immediate return to the reset state. The partially emitted sample is discarded and the history is not shifted.

Optional Feature:
- Macro: DQ_HISTORY_HOMING_EN.
- Defined: adds input port `homing` (1 bit).
  - When homing=1 in IDLE, all history entries are set to RESET_DQN on the next edge.
  - homing takes priority over a simultaneous dq_valid, which is not accepted that cycle (dq_ready=0 while homing=1).
  - homing is ignored outside IDLE.
- Undefined: no port; history is cleared only by reset.

Test Plan:
- Reset, then DQ=16'h0000 with out_ready=1: out_valid at t+1, taps 1..6 each dqn_out=11'h020, dq_out=16'h0000; last only on tap 6; dq_ready high at t+8.
- Feed DQ=16'h0005, then DQ=16'h8400: second sample tap1 dqn_out=11'h0E8. A third sample then shows tap1=11'h6E0, tap2=11'h0E8.
- Feed 16'h7FFF, then 16'h0000: tap1=11'h3FF. The zero sample later appears as 11'h020.
- Seven samples S1..S7: during S7, tap6=FLOATA(S1) and tap1=FLOATA(S6).
- Hold out_ready=0 for 3 cycles at tap 3: tap=3, dqn_out and dq_out stable; the sequence resumes at 4 with no skip.
- Assert reset during tap 4: out_valid drops asynchronously; the next sample emits 11'h020 on all taps.
- With the homing macro: pulse homing in IDLE after 3 nonzero samples; the next sample emits 11'h020 on all taps.
